// File: rtl/alu64bit_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu64bit_seq
//  Purpose  : Sequencing stage in front of the 64-bit gate-level ALU. Accepts
//             one operation over valid/ready, registers it onto the ALU
//             inputs, holds them for SETTLE_CYCLES clocks, samples s/cout and
//             offers the result downstream over a second valid/ready.
//  Options  : ALU_SEQ_ZERO_FLAG_EN adds the registered out_zero flag.
//  Revision : 1.0 - initial release
// ============================================================================
module alu64bit_seq #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    input  logic        in_cin,
    input  logic [1:0]  in_op,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic        alu_cin,
    output logic [1:0]  alu_op,
    input  logic [63:0] alu_s,
    input  logic        alu_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_s,
    output logic        out_cout,
    output logic        busy
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic        out_zero
`endif
);

    localparam int                C_CNT_W   = $clog2(SETTLE_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] c_CNT_LOAD = C_CNT_W'(SETTLE_CYCLES);
    localparam logic [C_CNT_W-1:0] c_CNT_ONE  = C_CNT_W'(1);

    // A zero settle time would sample the ALU in the same edge its inputs load.
    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("alu64bit_seq: SETTLE_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic               w_accept;

    // Ready only in IDLE and never while reset is asserted.
    assign in_ready = (r_state == S_IDLE) & ~rst;
    assign w_accept = in_valid & in_ready;

    // Control FSM with all ALU-side and result-side registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cin   <= 1'b0;
            alu_op    <= 2'b00;
            out_valid <= 1'b0;
            out_s     <= '0;
            out_cout  <= 1'b0;
            busy      <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            out_zero  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    // ALU operands are only rewritten on accept so the ALU
                    // does not toggle between operations.
                    if (w_accept) begin
                        alu_a   <= in_a;
                        alu_b   <= in_b;
                        alu_cin <= in_cin;
                        alu_op  <= in_op;
                        r_cnt   <= c_CNT_LOAD;
                        busy    <= 1'b1;
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                    // Count of 1 marks the edge SETTLE_CYCLES after accept.
                    if (r_cnt == c_CNT_ONE) begin
                        out_s     <= alu_s;
                        out_cout  <= alu_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                        out_zero  <= (alu_s == 64'd0);
`endif
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu64bit_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu64bit_seq
//  Purpose  : Scoreboard bench for alu64bit_seq. Two instances: SETTLE=4 for
//             the main flow and SETTLE=2 against a 3-cycle ALU stub to show
//             exactly when sampling happens. Stub ALU computes a^b and
//             passes cin to cout, both through 3 registers.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu64bit_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // SETTLE_CYCLES = 4 instance
    logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
    logic        alu_cin, alu_cout;
    logic [63:0] in_a, in_b, alu_a, alu_b, alu_s, out_s;
    logic [1:0]  in_op, alu_op;
    // SETTLE_CYCLES = 2 instance
    logic        in_valid2, in_ready2, in_cin2, out_valid2, out_ready2, out_cout2, busy2;
    logic        alu_cin2, alu_cout2;
    logic [63:0] in_a2, in_b2, alu_a2, alu_b2, alu_s2, out_s2;
    logic [1:0]  in_op2, alu_op2;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic        out_zero, out_zero2;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [63:0] s;
        logic        c;
    } res_t;
    res_t q4[$];
    res_t q2[$];

    alu64bit_seq #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
        .alu_s(alu_s), .alu_cout(alu_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_cout(out_cout), .busy(busy)
`ifdef ALU_SEQ_ZERO_FLAG_EN
        , .out_zero(out_zero)
`endif
    );

    alu64bit_seq #(.SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(in_a2), .in_b(in_b2), .in_cin(in_cin2), .in_op(in_op2),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_cin(alu_cin2), .alu_op(alu_op2),
        .alu_s(alu_s2), .alu_cout(alu_cout2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_s(out_s2), .out_cout(out_cout2), .busy(busy2)
`ifdef ALU_SEQ_ZERO_FLAG_EN
        , .out_zero(out_zero2)
`endif
    );

    // Behavioural ALU stubs with a 3-cycle registered delay.
    logic [63:0] s4_0, s4_1, s4_2, s2_0, s2_1, s2_2;
    logic [2:0]  c4, c2;
    always_ff @(posedge clk) begin
        if (rst) begin
            s4_0 <= '0; s4_1 <= '0; s4_2 <= '0; c4 <= '0;
            s2_0 <= '0; s2_1 <= '0; s2_2 <= '0; c2 <= '0;
        end else begin
            s4_0 <= alu_a ^ alu_b;   s4_1 <= s4_0; s4_2 <= s4_1; c4 <= {c4[1:0], alu_cin};
            s2_0 <= alu_a2 ^ alu_b2; s2_1 <= s2_0; s2_2 <= s2_1; c2 <= {c2[1:0], alu_cin2};
        end
    end
    assign alu_s     = s4_2;
    assign alu_cout  = c4[2];
    assign alu_s2    = s2_2;
    assign alu_cout2 = c2[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: compare whenever an output transfer is in progress.
    always @(negedge clk) begin : mon4
        res_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q4.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL sb4_unexpected: got out_s %h with nothing expected", out_s);
            end else begin
                e = q4.pop_front();
                check("sb4_s", out_s, e.s);
                check("sb4_cout", {63'd0, out_cout}, {63'd0, e.c});
`ifdef ALU_SEQ_ZERO_FLAG_EN
                check("sb4_zero", {63'd0, out_zero}, {63'd0, (e.s == 64'd0)});
`endif
            end
        end
    end

    always @(negedge clk) begin : mon2
        res_t e;
        if (out_valid2 === 1'b1 && out_ready2 === 1'b1) begin
            if (q2.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL sb2_unexpected: got out_s %h with nothing expected", out_s2);
            end else begin
                e = q2.pop_front();
                check("sb2_s", out_s2, e.s);
                check("sb2_cout", {63'd0, out_cout2}, {63'd0, e.c});
`ifdef ALU_SEQ_ZERO_FLAG_EN
                check("sb2_zero", {63'd0, out_zero2}, {63'd0, (e.s == 64'd0)});
`endif
            end
        end
    end

    // Issue one operation to the SETTLE=4 instance; returns just after accept.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input logic [1:0] op, input logic [63:0] es, input logic ec);
        int n;
        in_a = a; in_b = b; in_cin = cin; in_op = op; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL issue4_timeout: got in_ready 0 expected 1");
        end else begin
            q4.push_back('{s: es, c: ec});
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic issue2(input logic [63:0] a, input logic [63:0] b, input logic [63:0] es);
        int n;
        in_a2 = a; in_b2 = b; in_cin2 = 1'b0; in_op2 = 2'b00; in_valid2 = 1'b1;
        n = 0;
        while (!in_ready2 && n < 50) begin tick(); n++; end
        if (!in_ready2) begin
            n_cmp++; n_err++;
            $display("FAIL issue2_timeout: got in_ready 0 expected 1");
        end else begin
            q2.push_back('{s: es, c: 1'b0});
            tick();
        end
        in_valid2 = 1'b0;
    endtask

    task automatic wait_idle(input bit sel);
        int n;
        n = 0;
        while ((sel ? busy2 : busy) !== 1'b0 && n < 100) begin tick(); n++; end
        check(sel ? "idle2_timeout" : "idle4_timeout", {63'd0, (sel ? busy2 : busy)}, 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int   rise, vcnt, bcnt, n;
        logic hold_ok, seen;

        // Reset with in_valid asserted: nothing may be accepted.
        rst = 1'b1;
        in_valid = 1'b1; in_a = '1; in_b = 64'h1234; in_cin = 1'b1; in_op = 2'b11; out_ready = 1'b0;
        in_valid2 = 1'b1; in_a2 = '1; in_b2 = 64'h5; in_cin2 = 1'b1; in_op2 = 2'b11; out_ready2 = 1'b1;
        tick(); tick();
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_alu_a", alu_a, 64'd0);
        check("rst_alu_b", alu_b, 64'd0);
        check("rst_alu_cin_op", {61'd0, alu_cin, alu_op}, 64'd0);
        check("rst_out_s", out_s, 64'd0);
        check("rst_out_cout", {63'd0, out_cout}, 64'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        check("rst_out_zero", {63'd0, out_zero}, 64'd0);
`endif
        check("rst_busy2", {63'd0, busy2}, 64'd0);
        rst = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
        #1;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Settle margin: SETTLE=2 against a 3-cycle ALU samples stale results.
        issue2(64'd5, 64'd3, 64'd0);   // stale value from reset operands 0^0
        wait_idle(1'b1);
        issue2(64'd1, 64'd1, 64'd6);   // stale value from previous 5^3
        check("settle2_alu_a", alu_a2, 64'd1);
        wait_idle(1'b1);

        // Basic operation with out_ready already high.
        out_ready = 1'b1;
        issue(64'h00000000FFFFFFFF, 64'h0000FFFF0000FFFF, 1'b0, 2'b00, 64'h0000FFFFFFFF0000, 1'b0);
        check("basic_alu_a", alu_a, 64'h00000000FFFFFFFF);
        check("basic_alu_b", alu_b, 64'h0000FFFF0000FFFF);
        check("basic_alu_cin_op", {61'd0, alu_cin, alu_op}, 64'd0);
        check("basic_in_ready_low", {63'd0, in_ready}, 64'd0);
        rise = -1; vcnt = 0; bcnt = busy ? 1 : 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (out_valid) begin vcnt++; if (rise < 0) rise = i; end
            if (busy) bcnt++;
        end
        check("basic_valid_edge", 64'(rise), 64'd4);
        check("basic_valid_cycles", 64'(vcnt), 64'd1);
        check("basic_busy_cycles", 64'(bcnt), 64'd5);

        // Backpressure: result must hold and a second request must wait.
        out_ready = 1'b0;
        issue(64'h123456789ABCDEF0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 2'b10, 64'hEDCBA9876543210F, 1'b1);
        check("bp_alu_op", {62'd0, alu_op}, 64'd2);
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        check("bp_valid_rise", {63'd0, out_valid}, 64'd1);
        in_a = 64'hDEADBEEF00000001; in_b = 64'hDEADBEEF00000001; in_cin = 1'b0; in_op = 2'b00;
        in_valid = 1'b1;
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!(out_valid === 1'b1 && out_s === 64'hEDCBA9876543210F && out_cout === 1'b1 &&
                  in_ready === 1'b0 && alu_a === 64'h123456789ABCDEF0))
                hold_ok = 1'b0;
        end
        check("bp_hold", {63'd0, hold_ok}, 64'd1);
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", {63'd0, out_valid}, 64'd0);
        check("bp_release_ready", {63'd0, in_ready}, 64'd1);
        issue(64'hDEADBEEF00000001, 64'hDEADBEEF00000001, 1'b0, 2'b00, 64'd0, 1'b0);
        check("bp_second_alu_a", alu_a, 64'hDEADBEEF00000001);
        wait_idle(1'b0);
        issue(64'd1, 64'd0, 1'b0, 2'b00, 64'd1, 1'b0);
        wait_idle(1'b0);

        // Reset two cycles after accept: the operation is abandoned.
        in_a = 64'hFF; in_b = 64'h0F; in_cin = 1'b0; in_op = 2'b01; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        check("midrst_alu_a", alu_a, 64'd0);
        check("midrst_out_s", out_s, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_valid", {63'd0, seen}, 64'd0);
        issue(64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A, 1'b0, 2'b00, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        wait_idle(1'b0);

        tick(); tick();
        check("sb4_drained", 64'(q4.size()), 64'd0);
        check("sb2_drained", 64'(q2.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
